// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the execute ALU: resolves EX/MEM/WB bypassing,
// selects the immediate, and inserts one bubble per load-use hazard.
module id_ex_stage #(
    parameter int N = 32,
    parameter int R = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         valid_in,
    output logic         ready_out,
    input  logic         ready_in,
    input  logic         flush,
    input  logic [R-1:0] rs1_addr,
    input  logic [R-1:0] rs2_addr,
    input  logic [N-1:0] rs1_data,
    input  logic [N-1:0] rs2_data,
    input  logic [N-1:0] imm,
    input  logic         alusrc,
    input  logic [1:0]   alucontrol_in,
    input  logic [R-1:0] rd_in,
    input  logic         regwrite_in,
    input  logic         memread_in,
    input  logic         memwrite_in,
    input  logic [N-1:0] ex_result,
    input  logic [R-1:0] mem_rd,
    input  logic [R-1:0] wb_rd,
    input  logic         mem_we,
    input  logic         wb_we,
    input  logic [N-1:0] mem_data,
    input  logic [N-1:0] wb_data,
    output logic [N-1:0] ALUA,
    output logic [N-1:0] ALUB,
    output logic [1:0]   ALUControl,
    output logic [N-1:0] store_data,
    output logic [R-1:0] rd_out,
    output logic         valid_out,
    output logic         regwrite_out,
    output logic         memread_out,
    output logic         memwrite_out
);

    logic         ex_fwd_ok;
    logic         hz;
    logic [N-1:0] fwd_rs1;
    logic [N-1:0] fwd_rs2;

    // A held load has no result yet, so only non-load producers bypass from EX.
    assign ex_fwd_ok = valid_out & regwrite_out & ~memread_out;

    always_comb begin
        fwd_rs1 = rs1_data;
        if (rs1_addr == '0)
            fwd_rs1 = '0;
        else if (ex_fwd_ok && rd_out == rs1_addr)
            fwd_rs1 = ex_result;
        else if (mem_we && mem_rd == rs1_addr)
            fwd_rs1 = mem_data;
        else if (wb_we && wb_rd == rs1_addr)
            fwd_rs1 = wb_data;
    end

    always_comb begin
        fwd_rs2 = rs2_data;
        if (rs2_addr == '0)
            fwd_rs2 = '0;
        else if (ex_fwd_ok && rd_out == rs2_addr)
            fwd_rs2 = ex_result;
        else if (mem_we && mem_rd == rs2_addr)
            fwd_rs2 = mem_data;
        else if (wb_we && wb_rd == rs2_addr)
            fwd_rs2 = wb_data;
    end

    // rs2 only matters when it feeds ALUB or is the value being stored.
    assign hz = valid_in & valid_out & memread_out & (rd_out != '0) &
                ((rd_out == rs1_addr) |
                 ((rd_out == rs2_addr) & (~alusrc | memwrite_in)));

    // Handshake: a beat transfers on a cycle where valid_in & ready_out; decode
    // must hold its instruction stable until then. ready_in = 0 freezes the stage.
    assign ready_out = ready_in & ~hz & ~reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ALUA         <= '0;
            ALUB         <= '0;
            ALUControl   <= '0;
            store_data   <= '0;
            rd_out       <= '0;
            valid_out    <= 1'b0;
            regwrite_out <= 1'b0;
            memread_out  <= 1'b0;
            memwrite_out <= 1'b0;
        end else if (flush) begin
            valid_out    <= 1'b0;
            regwrite_out <= 1'b0;
            memread_out  <= 1'b0;
            memwrite_out <= 1'b0;
        end else if (!ready_in) begin
            ALUA         <= ALUA;
            ALUB         <= ALUB;
            ALUControl   <= ALUControl;
            store_data   <= store_data;
            rd_out       <= rd_out;
            valid_out    <= valid_out;
            regwrite_out <= regwrite_out;
            memread_out  <= memread_out;
            memwrite_out <= memwrite_out;
        end else if (valid_in && !hz) begin
            ALUA         <= fwd_rs1;
            ALUB         <= alusrc ? imm : fwd_rs2;
            ALUControl   <= alucontrol_in;
            store_data   <= fwd_rs2;
            rd_out       <= rd_in;
            valid_out    <= 1'b1;
            regwrite_out <= regwrite_in;
            memread_out  <= memread_in;
            memwrite_out <= memwrite_in;
        end else begin
            // Bubble (load-use or idle decode): data registers keep their values.
            valid_out    <= 1'b0;
            regwrite_out <= 1'b0;
            memread_out  <= 1'b0;
            memwrite_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a vector table for forwarding/hazard rows plus
// hand-written stall, flush and asynchronous-reset sequences.
module tb_id_ex_stage;

    localparam int N = 32;
    localparam int R = 5;

    logic         clk = 1'b0;
    logic         reset;
    logic         valid_in, ready_out, ready_in, flush;
    logic [R-1:0] rs1_addr, rs2_addr, rd_in, mem_rd, wb_rd, rd_out;
    logic [N-1:0] rs1_data, rs2_data, imm, ex_result, mem_data, wb_data;
    logic         alusrc, regwrite_in, memread_in, memwrite_in, mem_we, wb_we;
    logic [1:0]   alucontrol_in, ALUControl;
    logic [N-1:0] ALUA, ALUB, store_data;
    logic         valid_out, regwrite_out, memread_out, memwrite_out;

    int cmp_count  = 0;
    int fail_count = 0;
    logic [31:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    id_ex_stage #(.N(N), .R(R)) dut (
        .clk(clk), .reset(reset),
        .valid_in(valid_in), .ready_out(ready_out), .ready_in(ready_in), .flush(flush),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .imm(imm), .alusrc(alusrc), .alucontrol_in(alucontrol_in), .rd_in(rd_in),
        .regwrite_in(regwrite_in), .memread_in(memread_in), .memwrite_in(memwrite_in),
        .ex_result(ex_result), .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_we(mem_we), .wb_we(wb_we),
        .mem_data(mem_data), .wb_data(wb_data),
        .ALUA(ALUA), .ALUB(ALUB), .ALUControl(ALUControl), .store_data(store_data),
        .rd_out(rd_out), .valid_out(valid_out), .regwrite_out(regwrite_out),
        .memread_out(memread_out), .memwrite_out(memwrite_out)
    );

    typedef struct {
        logic         valid_in, ready_in, flush, alusrc;
        logic         regwrite, memread, memwrite, mem_we, wb_we;
        logic [R-1:0] rs1_addr, rs2_addr, rd_in, mem_rd, wb_rd;
        logic [N-1:0] rs1_data, rs2_data, imm, ex_result, mem_data, wb_data;
        logic [1:0]   aluc;
        logic         exp_ready, chk_data;
        logic         exp_valid, exp_rw, exp_mr, exp_mw;
        logic [1:0]   exp_aluc;
        logic [R-1:0] exp_rd;
        logic [N-1:0] exp_a, exp_b, exp_sd;
    } vec_t;

    function automatic vec_t vdef();
        vec_t v;
        v.valid_in = 1'b1; v.ready_in = 1'b1; v.flush = 1'b0; v.alusrc = 1'b0;
        v.regwrite = 1'b0; v.memread = 1'b0; v.memwrite = 1'b0;
        v.mem_we = 1'b0; v.wb_we = 1'b0;
        v.rs1_addr = '0; v.rs2_addr = '0; v.rd_in = '0; v.mem_rd = '0; v.wb_rd = '0;
        v.rs1_data = '0; v.rs2_data = '0; v.imm = '0;
        v.ex_result = '0; v.mem_data = '0; v.wb_data = '0;
        v.aluc = 2'b00;
        v.exp_ready = 1'b1; v.chk_data = 1'b1;
        v.exp_valid = 1'b0; v.exp_rw = 1'b0; v.exp_mr = 1'b0; v.exp_mw = 1'b0;
        v.exp_aluc = 2'b00; v.exp_rd = '0;
        v.exp_a = '0; v.exp_b = '0; v.exp_sd = '0;
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input vec_t v);
        valid_in = v.valid_in; ready_in = v.ready_in; flush = v.flush;
        rs1_addr = v.rs1_addr; rs2_addr = v.rs2_addr;
        rs1_data = v.rs1_data; rs2_data = v.rs2_data;
        imm = v.imm; alusrc = v.alusrc; alucontrol_in = v.aluc; rd_in = v.rd_in;
        regwrite_in = v.regwrite; memread_in = v.memread; memwrite_in = v.memwrite;
        ex_result = v.ex_result; mem_rd = v.mem_rd; wb_rd = v.wb_rd;
        mem_we = v.mem_we; wb_we = v.wb_we; mem_data = v.mem_data; wb_data = v.wb_data;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_count++;
        if (act !== exp) begin
            fail_count++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".ready_out"},    32'(ready_out),    32'h0);
        check({tag, ".valid_out"},    32'(valid_out),    32'h0);
        check({tag, ".regwrite_out"}, 32'(regwrite_out), 32'h0);
        check({tag, ".memread_out"},  32'(memread_out),  32'h0);
        check({tag, ".memwrite_out"}, 32'(memwrite_out), 32'h0);
        check({tag, ".ALUControl"},   32'(ALUControl),   32'h0);
        check({tag, ".rd_out"},       32'(rd_out),       32'h0);
        check({tag, ".ALUA"},         ALUA,              32'h0);
        check({tag, ".ALUB"},         ALUB,              32'h0);
        check({tag, ".store_data"},   store_data,        32'h0);
    endtask

    // Drive one row between edges, check ready_out before the edge and the
    // registered outputs just after it.
    task automatic apply_row(input string tag, input vec_t v);
        @(negedge clk);
        drive(v);
        #1;
        check({tag, ".ready_out"}, 32'(ready_out), 32'(v.exp_ready));
        exp_q.push_back(32'(v.exp_valid));
        exp_q.push_back(32'(v.exp_rw));
        exp_q.push_back(32'(v.exp_mr));
        exp_q.push_back(32'(v.exp_mw));
        if (v.chk_data) begin
            exp_q.push_back(32'(v.exp_aluc));
            exp_q.push_back(32'(v.exp_rd));
            exp_q.push_back(v.exp_a);
            exp_q.push_back(v.exp_b);
            exp_q.push_back(v.exp_sd);
        end
        @(posedge clk);
        #1;
        check({tag, ".valid_out"},    32'(valid_out),    exp_q.pop_front());
        check({tag, ".regwrite_out"}, 32'(regwrite_out), exp_q.pop_front());
        check({tag, ".memread_out"},  32'(memread_out),  exp_q.pop_front());
        check({tag, ".memwrite_out"}, 32'(memwrite_out), exp_q.pop_front());
        if (v.chk_data) begin
            check({tag, ".ALUControl"}, 32'(ALUControl), exp_q.pop_front());
            check({tag, ".rd_out"},     32'(rd_out),     exp_q.pop_front());
            check({tag, ".ALUA"},       ALUA,            exp_q.pop_front());
            check({tag, ".ALUB"},       ALUB,            exp_q.pop_front());
            check({tag, ".store_data"}, store_data,      exp_q.pop_front());
        end
    endtask

    vec_t vecs[13];
    vec_t v;

    initial begin
        // Row 0: plain capture, sub.
        v = vdef(); v.rs1_addr = 1; v.rs1_data = 5; v.rs2_addr = 2; v.rs2_data = 7;
        v.aluc = 2'b01; v.rd_in = 3; v.regwrite = 1;
        v.exp_valid = 1; v.exp_rw = 1; v.exp_aluc = 2'b01; v.exp_rd = 3;
        v.exp_a = 5; v.exp_b = 7; v.exp_sd = 7; vecs[0] = v;
        // Row 1: EX beats MEM on rs1.
        v = vdef(); v.rs1_addr = 3; v.rs1_data = 32'h99; v.ex_result = 32'h10;
        v.mem_we = 1; v.mem_rd = 3; v.mem_data = 32'h20; v.rs2_addr = 5; v.rs2_data = 1;
        v.rd_in = 7; v.regwrite = 1;
        v.exp_valid = 1; v.exp_rw = 1; v.exp_rd = 7;
        v.exp_a = 32'h10; v.exp_b = 1; v.exp_sd = 1; vecs[1] = v;
        // Row 2: rs1 = x0 never forwarded; rs2 from EX into store_data; ALUB = imm; lw.
        v = vdef(); v.rs1_addr = 0; v.rs1_data = 32'h77; v.mem_we = 1; v.mem_rd = 0;
        v.mem_data = 32'hBB; v.wb_we = 1; v.wb_rd = 0; v.wb_data = 32'hAA;
        v.rs2_addr = 7; v.rs2_data = 32'h5; v.ex_result = 32'h30; v.alusrc = 1; v.imm = 8;
        v.rd_in = 4; v.regwrite = 1; v.memread = 1;
        v.exp_valid = 1; v.exp_rw = 1; v.exp_mr = 1; v.exp_rd = 4;
        v.exp_a = 0; v.exp_b = 8; v.exp_sd = 32'h30; vecs[2] = v;
        // Row 3: load-use on rs2 -> stall, bubble.
        v = vdef(); v.rs1_addr = 1; v.rs1_data = 2; v.rs2_addr = 4; v.rs2_data = 32'h66;
        v.aluc = 2'b01; v.rd_in = 9; v.regwrite = 1;
        v.exp_ready = 0; v.chk_data = 0; vecs[3] = v;
        // Row 4: retry picks up MEM.
        v = vecs[3]; v.mem_we = 1; v.mem_rd = 4; v.mem_data = 32'h55;
        v.exp_ready = 1; v.chk_data = 1; v.exp_valid = 1; v.exp_rw = 1;
        v.exp_aluc = 2'b01; v.exp_rd = 9; v.exp_a = 2; v.exp_b = 32'h55; v.exp_sd = 32'h55;
        vecs[4] = v;
        // Row 5: lw x8.
        v = vdef(); v.rs1_addr = 2; v.rs1_data = 32'h100; v.alusrc = 1; v.imm = 4;
        v.rd_in = 8; v.regwrite = 1; v.memread = 1;
        v.exp_valid = 1; v.exp_rw = 1; v.exp_mr = 1; v.exp_rd = 8;
        v.exp_a = 32'h100; v.exp_b = 4; v.exp_sd = 0; vecs[5] = v;
        // Row 6: rs2 matches load but is unused (alusrc, not a store) -> no hazard.
        v = vdef(); v.rs1_addr = 3; v.rs1_data = 32'h11; v.rs2_addr = 8; v.alusrc = 1;
        v.imm = 3; v.rd_in = 10; v.regwrite = 1;
        v.exp_valid = 1; v.exp_rw = 1; v.exp_rd = 10;
        v.exp_a = 32'h11; v.exp_b = 3; v.exp_sd = 0; vecs[6] = v;
        // Row 7: store, rs1 from WB, rs2 from MEM.
        v = vdef(); v.rs1_addr = 12; v.rs1_data = 1; v.wb_we = 1; v.wb_rd = 12;
        v.wb_data = 32'hCAFE; v.rs2_addr = 13; v.rs2_data = 2; v.mem_we = 1; v.mem_rd = 13;
        v.mem_data = 32'hBEEF; v.alusrc = 1; v.imm = 32'h10; v.memwrite = 1;
        v.exp_valid = 1; v.exp_mw = 1; v.exp_rd = 0;
        v.exp_a = 32'hCAFE; v.exp_b = 32'h10; v.exp_sd = 32'hBEEF; vecs[7] = v;
        // Row 8: MEM disabled -> WB used for both sources.
        v = vdef(); v.rs1_addr = 14; v.rs1_data = 32'h14; v.rs2_addr = 14;
        v.rs2_data = 32'h15; v.mem_we = 0; v.mem_rd = 14; v.mem_data = 32'hDEAD;
        v.wb_we = 1; v.wb_rd = 14; v.wb_data = 32'h1414; v.aluc = 2'b01;
        v.rd_in = 11; v.regwrite = 1;
        v.exp_valid = 1; v.exp_rw = 1; v.exp_aluc = 2'b01; v.exp_rd = 11;
        v.exp_a = 32'h1414; v.exp_b = 32'h1414; v.exp_sd = 32'h1414; vecs[8] = v;
        // Row 9: idle decode -> bubble.
        v = vdef(); v.valid_in = 0; v.regwrite = 1; v.chk_data = 0; vecs[9] = v;
        // Row 10: lw x5.
        v = vdef(); v.alusrc = 1; v.imm = 32'h20; v.rd_in = 5; v.regwrite = 1;
        v.memread = 1;
        v.exp_valid = 1; v.exp_rw = 1; v.exp_mr = 1; v.exp_rd = 5;
        v.exp_a = 0; v.exp_b = 32'h20; v.exp_sd = 0; vecs[10] = v;
        // Row 11: store of the loaded register -> hazard even with alusrc.
        v = vdef(); v.rs1_addr = 1; v.rs1_data = 32'h40; v.rs2_addr = 5; v.alusrc = 1;
        v.imm = 4; v.memwrite = 1; v.exp_ready = 0; v.chk_data = 0; vecs[11] = v;
        // Row 12: retry with MEM forwarding into store_data.
        v = vecs[11]; v.mem_we = 1; v.mem_rd = 5; v.mem_data = 32'h77;
        v.exp_ready = 1; v.chk_data = 1; v.exp_valid = 1; v.exp_mw = 1; v.exp_rd = 0;
        v.exp_a = 32'h40; v.exp_b = 4; v.exp_sd = 32'h77; vecs[12] = v;

        // Reset state, with decode already offering a beat.
        reset = 1'b1;
        drive(vdef());
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 13; i++)
            apply_row($sformatf("row%0d", i), vecs[i]);

        // Stall: three frozen cycles with changing decode data.
        for (int i = 0; i < 3; i++) begin
            v = vdef(); v.ready_in = 0; v.rs1_addr = 1; v.rs1_data = 32'h100 + i;
            v.rd_in = 5'(20 + i); v.regwrite = 1; v.exp_ready = 0;
            v.exp_valid = 1; v.exp_mw = 1; v.exp_rd = 0;
            v.exp_a = 32'h40; v.exp_b = 4; v.exp_sd = 32'h77;
            apply_row($sformatf("stall%0d", i), v);
        end
        v = vdef(); v.rs1_addr = 1; v.rs1_data = 3; v.rs2_addr = 2; v.rs2_data = 4;
        v.aluc = 2'b01; v.rd_in = 6; v.regwrite = 1;
        v.exp_valid = 1; v.exp_rw = 1; v.exp_aluc = 2'b01; v.exp_rd = 6;
        v.exp_a = 3; v.exp_b = 4; v.exp_sd = 4;
        apply_row("stall_release", v);

        // Flush while stalled, then flush discarding an accepted beat.
        v = vdef(); v.ready_in = 0; v.flush = 1; v.rs1_addr = 2; v.rs1_data = 9;
        v.regwrite = 1; v.memwrite = 1; v.exp_ready = 0; v.chk_data = 0;
        apply_row("flush_stalled", v);
        v = vdef(); v.flush = 1; v.rs1_addr = 2; v.rs1_data = 9; v.regwrite = 1;
        v.memwrite = 1; v.exp_ready = 1; v.chk_data = 0;
        apply_row("flush_accept", v);

        // Asynchronous reset mid-cycle while valid_out = 1.
        v = vdef(); v.rs1_addr = 2; v.rs1_data = 9; v.aluc = 2'b01; v.rd_in = 7;
        v.regwrite = 1;
        v.exp_valid = 1; v.exp_rw = 1; v.exp_aluc = 2'b01; v.exp_rd = 7;
        v.exp_a = 9; v.exp_b = 0; v.exp_sd = 0;
        apply_row("pre_reset", v);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        @(posedge clk);
        #1;
        check("reset_hold.valid_out", 32'(valid_out), 32'h0);
        check("reset_hold.ALUA", ALUA, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        apply_row("post_reset", v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
        $finish;
    end

endmodule
